// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB master port among PORTS requesters.
// Fully registered outputs; an ACCESS phase can be ended early by a timeout that reports an error.
module apb_arbiter #(
  parameter int PORTS      = 4,
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [PORTS-1:0]               S_PSEL,
  input  logic [PORTS-1:0]               S_PENABLE,
  input  logic [PORTS*PADDR_SIZE-1:0]    S_PADDR,
  input  logic [PORTS-1:0]               S_PWRITE,
  input  logic [PORTS*PDATA_SIZE-1:0]    S_PWDATA,
  input  logic [PORTS*PDATA_SIZE/8-1:0]  S_PSTRB,
  input  logic [PORTS*3-1:0]             S_PPROT,
  output logic [PORTS-1:0]               S_PREADY,
  output logic [PDATA_SIZE-1:0]          S_PRDATA,
  output logic                           S_PSLVERR,
  output logic                           M_PSEL,
  output logic                           M_PENABLE,
  output logic                           M_PWRITE,
  output logic [PADDR_SIZE-1:0]          M_PADDR,
  output logic [PDATA_SIZE-1:0]          M_PWDATA,
  output logic [PDATA_SIZE/8-1:0]        M_PSTRB,
  output logic [2:0]                     M_PPROT,
  input  logic [PDATA_SIZE-1:0]          M_PRDATA,
  input  logic                           M_PREADY,
  input  logic                           M_PSLVERR,
  output logic [PORTS-1:0]               GRANT
);

  localparam int SW    = PDATA_SIZE / 8;
  localparam int GW    = $clog2(PORTS);
  localparam int IW    = GW + 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;

  state_t                  state, state_d;
  logic [GW-1:0]           last_grant, last_grant_d, grant_idx;
  logic [IW-1:0]           cand;
  logic                    found;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    timed_out;
  logic [PORTS-1:0]        grant_d, s_pready_d;
  logic [PDATA_SIZE-1:0]   s_prdata_d, m_pwdata_d;
  logic                    s_pslverr_d, m_psel_d, m_penable_d, m_pwrite_d;
  logic [PADDR_SIZE-1:0]   m_paddr_d;
  logic [SW-1:0]           m_pstrb_d;
  logic [2:0]              m_pprot_d;
  logic                    unused_penable;

  // PENABLE from requesters carries no information the arbiter needs
  assign unused_penable = ^S_PENABLE;

  // Search last_grant+1 .. last_grant+PORTS, wrapping without a divider
  always_comb begin
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = {1'b0, last_grant} + IW'(i);
      if (cand >= IW'(PORTS)) cand = cand - IW'(PORTS);
      if (!found && S_PSEL[cand[GW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    grant_d      = GRANT;
    s_pready_d   = S_PREADY;
    s_prdata_d   = S_PRDATA;
    s_pslverr_d  = S_PSLVERR;
    m_psel_d     = M_PSEL;
    m_penable_d  = M_PENABLE;
    m_pwrite_d   = M_PWRITE;
    m_paddr_d    = M_PADDR;
    m_pwdata_d   = M_PWDATA;
    m_pstrb_d    = M_PSTRB;
    m_pprot_d    = M_PPROT;
    timed_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|S_PSEL) begin
          state_d             = ST_SETUP;
          last_grant_d        = grant_idx;
          grant_d             = '0;
          grant_d[grant_idx]  = 1'b1;
          m_psel_d            = 1'b1;
          m_penable_d         = 1'b0;
          m_pwrite_d          = S_PWRITE[grant_idx];
          m_paddr_d           = S_PADDR[grant_idx*PADDR_SIZE +: PADDR_SIZE];
          m_pwdata_d          = S_PWDATA[grant_idx*PDATA_SIZE +: PDATA_SIZE];
          m_pstrb_d           = S_PSTRB[grant_idx*SW +: SW];
          m_pprot_d           = S_PPROT[grant_idx*3 +: 3];
        end
      end
      ST_SETUP: begin
        state_d     = ST_ACCESS;
        m_penable_d = 1'b1;
        cnt_d       = '0;
      end
      ST_ACCESS: begin
        timed_out = (TIMEOUT > 0) && !M_PREADY && (cnt == CNT_LAST);
        if (M_PREADY || timed_out) begin
          state_d     = ST_DONE;
          s_pready_d  = GRANT;
          s_prdata_d  = timed_out ? '0 : M_PRDATA;
          s_pslverr_d = timed_out | M_PSLVERR;
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
        end else if (TIMEOUT > 0) begin
          // cannot pass CNT_LAST: reaching it ends the transfer
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        s_pready_d = '0;
        grant_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      last_grant <= GW'(PORTS - 1);
      cnt        <= '0;
      GRANT      <= '0;
      S_PREADY   <= '0;
      S_PRDATA   <= '0;
      S_PSLVERR  <= 1'b0;
      M_PSEL     <= 1'b0;
      M_PENABLE  <= 1'b0;
      M_PWRITE   <= 1'b0;
      M_PADDR    <= '0;
      M_PWDATA   <= '0;
      M_PSTRB    <= '0;
      M_PPROT    <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
      GRANT      <= grant_d;
      S_PREADY   <= s_pready_d;
      S_PRDATA   <= s_prdata_d;
      S_PSLVERR  <= s_pslverr_d;
      M_PSEL     <= m_psel_d;
      M_PENABLE  <= m_penable_d;
      M_PWRITE   <= m_pwrite_d;
      M_PADDR    <= m_paddr_d;
      M_PWDATA   <= m_pwdata_d;
      M_PSTRB    <= m_pstrb_d;
      M_PPROT    <= m_pprot_d;
    end
  end

endmodule
